tlc_multiphase_ctrl: RTL and testbench

- Parametrised multi-phase traffic light controller: the successor to the fixed six-light controller.
- Sequences `N_PHASES` signal phases, each driving a configurable set of `N_LIGHTS` lights.
- Each phase runs GREEN, then YELLOW, then all-red clearance, with per-phase programmable green time.
- Adds a latched pedestrian walk interval and an emergency pre-emption mode; `count`/`ps` debug outputs are kept for bench visibility.

---
 rtl/tlc_pkg.sv | 24 ++
 rtl/tlc_down_counter.sv | 29 ++
 rtl/tlc_multiphase_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tlc_multiphase_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared light codes, state encoding and duration helper for the traffic light controller
package tlc_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    // Working width for duration arithmetic; wide enough for any CNT_W used here.
    localparam int DUR_W = 16;

    typedef enum logic [3:0] {
        ST_ALLRED  = 4'd0,
        ST_GREEN   = 4'd1,
        ST_YELLOW  = 4'd2,
        ST_WALK    = 4'd3,
        ST_PREEMPT = 4'd4
    } state_t;

    // A programmed duration of zero still occupies one cycle.
    function automatic logic [DUR_W-1:0] max1(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? DUR_W'(1) : dur;
    endfunction

endpackage

// File: rtl/tlc_down_counter.sv
// rtl/tlc_down_counter.sv - loadable saturating down counter with hold and zero flag
// Ports: clk, rst (sync, active-low), load/load_val (load has priority),
//        hold (freeze), value (current count), zero (value == 0).
module tlc_down_counter #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (!hold && value != '0) begin
            value <= value - CNT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/tlc_multiphase_ctrl.sv
// rtl/tlc_multiphase_ctrl.sv - parametrised multi-phase traffic light controller with walk and pre-emption
// Ports: clk, rst (sync, active-low); phase_mask/green_time/yellow_time (per-phase config);
//        ped_req (pulse), emerg/emerg_phase (pre-emption); lights (2 bits per light),
//        ped_walk, ped_wait, phase, count (remaining cycles - 1), ps (present state).
module tlc_multiphase_ctrl
    import tlc_pkg::*;
#(
    parameter int N_LIGHTS  = 6,
    parameter int N_PHASES  = 4,
    parameter int CNT_W     = 4,
    parameter int CLR_TIME  = 2,
    parameter int WALK_TIME = 5,
    parameter int PH_W      = $clog2(N_PHASES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PHASES*N_LIGHTS-1:0] phase_mask,
    input  logic [N_PHASES*CNT_W-1:0]    green_time,
    input  logic [CNT_W-1:0]             yellow_time,
    input  logic                         ped_req,
    input  logic                         emerg,
    input  logic [PH_W-1:0]              emerg_phase,
    output logic [2*N_LIGHTS-1:0]        lights,
    output logic                         ped_walk,
    output logic                         ped_wait,
    output logic [PH_W-1:0]              phase,
    output logic [CNT_W-1:0]             count,
    output logic [3:0]                   ps
);

    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_TIME - 1);
    localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_TIME - 1);

    // Counter load value for a programmed duration (count runs dur-1 .. 0).
    function automatic logic [CNT_W-1:0] dur_load(input logic [CNT_W-1:0] dur);
        return CNT_W'(max1(DUR_W'(dur)) - DUR_W'(1));
    endfunction

    state_t                state, state_nxt;
    logic [PH_W-1:0]       phase_r, phase_nxt, phase_seq;
    logic [N_LIGHTS-1:0]   cur_mask, mask_nxt, mask_seq;
    logic [CNT_W-1:0]      green_seq_load, yellow_load;
    logic                  cnt_load, cnt_zero;
    logic [CNT_W-1:0]      cnt_val;
    logic                  walk_done, walk_abort;
    logic                  ped_wait_r, ped_again;

    // Next phase in the normal rotation and its configuration.
    assign phase_seq      = (phase_r == PH_W'(N_PHASES - 1)) ? '0 : phase_r + PH_W'(1);
    assign mask_seq       = phase_mask[int'(phase_seq)*N_LIGHTS +: N_LIGHTS];
    assign green_seq_load = dur_load(green_time[int'(phase_seq)*CNT_W +: CNT_W]);
    assign yellow_load    = dur_load(yellow_time);

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase_r;
        mask_nxt   = cur_mask;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        walk_done  = 1'b0;
        walk_abort = 1'b0;
        case (state)
            ST_ALLRED: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (emerg) begin
                        state_nxt = ST_PREEMPT;
                        phase_nxt = emerg_phase;
                        mask_nxt  = phase_mask[int'(emerg_phase)*N_LIGHTS +: N_LIGHTS];
                        cnt_val   = '0;
                    end else if (ped_wait_r) begin
                        state_nxt = ST_WALK;
                        cnt_val   = WALK_LOAD;
                    end else begin
                        state_nxt = ST_GREEN;
                        phase_nxt = phase_seq;
                        mask_nxt  = mask_seq;
                        cnt_val   = green_seq_load;
                    end
                end
            end
            ST_GREEN: begin
                // Pre-empting the phase already green keeps its mask so lights do not blink.
                if (emerg && phase_r == emerg_phase) begin
                    state_nxt = ST_PREEMPT;
                    cnt_load  = 1'b1;
                    cnt_val   = '0;
                end else if (emerg || cnt_zero) begin
                    state_nxt = ST_YELLOW;
                    cnt_load  = 1'b1;
                    cnt_val   = yellow_load;
                end
            end
            ST_YELLOW: begin
                if (cnt_zero) begin
                    state_nxt = ST_ALLRED;
                    cnt_load  = 1'b1;
                    cnt_val   = CLR_LOAD;
                end
            end
            ST_WALK: begin
                if (emerg) begin
                    state_nxt  = ST_ALLRED;
                    cnt_load   = 1'b1;
                    cnt_val    = CLR_LOAD;
                    walk_abort = 1'b1;
                end else if (cnt_zero) begin
                    state_nxt = ST_GREEN;
                    phase_nxt = phase_seq;
                    mask_nxt  = mask_seq;
                    cnt_load  = 1'b1;
                    cnt_val   = green_seq_load;
                    walk_done = 1'b1;
                end
            end
            ST_PREEMPT: begin
                if (!emerg) begin
                    state_nxt = ST_YELLOW;
                    cnt_load  = 1'b1;
                    cnt_val   = yellow_load;
                end
            end
            default: begin
                state_nxt = ST_ALLRED;
                cnt_load  = 1'b1;
                cnt_val   = CLR_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_ALLRED;
            phase_r    <= PH_W'(N_PHASES - 1);
            cur_mask   <= '0;
            ped_wait_r <= 1'b0;
            ped_again  <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase_r  <= phase_nxt;
            cur_mask <= mask_nxt;
            // A request seen during the walk survives the completion clear.
            if (walk_done) begin
                ped_wait_r <= ped_req | ped_again;
            end else if (ped_req) begin
                ped_wait_r <= 1'b1;
            end
            if (walk_done || walk_abort) begin
                ped_again <= 1'b0;
            end else if (state == ST_WALK && ped_req) begin
                ped_again <= 1'b1;
            end
        end
    end

    tlc_down_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (CLR_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .hold     (state == ST_PREEMPT),
        .value    (count),
        .zero     (cnt_zero)
    );

    always_comb begin
        lights = '0;
        for (int i = 0; i < N_LIGHTS; i++) begin
            if (cur_mask[i]) begin
                if (state == ST_GREEN || state == ST_PREEMPT) begin
                    lights[2*i +: 2] = LIGHT_GREEN;
                end else if (state == ST_YELLOW) begin
                    lights[2*i +: 2] = LIGHT_YELLOW;
                end
            end
        end
    end

    assign ped_walk = (state == ST_WALK);
    assign ped_wait = ped_wait_r;
    assign phase    = phase_r;
    assign ps       = state;

endmodule

// File: tb/tb_tlc_multiphase_ctrl.sv
// tb/tb_tlc_multiphase_ctrl.sv - self-checking bench for tlc_multiphase_ctrl
module tb_tlc_multiphase_ctrl;

    localparam int NL   = 6;
    localparam int NP   = 4;
    localparam int CW   = 4;
    localparam int CLR  = 2;
    localparam int WALK = 5;

    localparam logic [NP*NL-1:0] DEF_MASK  = {6'b001010, 6'b000101, 6'b100010, 6'b010001};
    localparam logic [NP*CW-1:0] DEF_GREEN = {4'd2, 4'd3, 4'd4, 4'd5};

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*NL-1:0]  phase_mask;
    logic [NP*CW-1:0]  green_time;
    logic [CW-1:0]     yellow_time;
    logic              ped_req;
    logic              emerg;
    logic [1:0]        emerg_phase;
    logic [2*NL-1:0]   lights;
    logic              ped_walk;
    logic              ped_wait;
    logic [1:0]        phase;
    logic [CW-1:0]     count;
    logic [3:0]        ps;

    int n_cmp = 0;
    int n_err = 0;

    tlc_multiphase_ctrl #(
        .N_LIGHTS (NL), .N_PHASES (NP), .CNT_W (CW), .CLR_TIME (CLR), .WALK_TIME (WALK)
    ) dut (
        .clk (clk), .rst (rst), .phase_mask (phase_mask), .green_time (green_time),
        .yellow_time (yellow_time), .ped_req (ped_req), .emerg (emerg),
        .emerg_phase (emerg_phase), .lights (lights), .ped_walk (ped_walk),
        .ped_wait (ped_wait), .phase (phase), .count (count), .ps (ps)
    );

    always #5 clk = ~clk;

    // Reference model: m_rem is the number of cycles left in the current interval.
    int          m_state, m_phase, m_rem, m_nph;
    logic [NL-1:0] m_mask;
    bit          m_wait, m_again, m_done;

    function automatic int dur1(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk) begin
        m_done = 0;
        if (!rst) begin
            m_state = 0; m_rem = CLR; m_phase = NP - 1; m_mask = '0; m_wait = 0; m_again = 0;
        end else begin
            m_nph = (m_phase + 1) % NP;
            case (m_state)
                0: if (m_rem == 1) begin
                       if (emerg) begin
                           m_state = 4; m_phase = int'(emerg_phase); m_rem = 1;
                           m_mask = phase_mask[int'(emerg_phase)*NL +: NL];
                       end else if (m_wait) begin
                           m_state = 3; m_rem = WALK;
                       end else begin
                           m_state = 1; m_phase = m_nph; m_mask = phase_mask[m_nph*NL +: NL];
                           m_rem = dur1(int'(green_time[m_nph*CW +: CW]));
                       end
                   end else m_rem--;
                1: if (emerg && m_phase == int'(emerg_phase)) begin
                       m_state = 4; m_rem = 1;
                   end else if (emerg || m_rem == 1) begin
                       m_state = 2; m_rem = dur1(int'(yellow_time));
                   end else m_rem--;
                2: if (m_rem == 1) begin m_state = 0; m_rem = CLR; end else m_rem--;
                3: if (emerg) begin
                       m_state = 0; m_rem = CLR; m_again = 0;
                   end else if (m_rem == 1) begin
                       m_state = 1; m_phase = m_nph; m_mask = phase_mask[m_nph*NL +: NL];
                       m_rem = dur1(int'(green_time[m_nph*CW +: CW])); m_done = 1;
                   end else begin
                       m_rem--; m_again = m_again | ped_req;
                   end
                default: if (!emerg) begin m_state = 2; m_rem = dur1(int'(yellow_time)); end
            endcase
            if (m_done) begin m_wait = ped_req | m_again; m_again = 0; end
            else m_wait = m_wait | ped_req;
        end
    end

    function automatic logic [2*NL-1:0] exp_lights(input int st, input logic [NL-1:0] msk);
        logic [2*NL-1:0] l;
        l = '0;
        for (int i = 0; i < NL; i++)
            if (msk[i]) l[2*i +: 2] = (st == 1 || st == 4) ? 2'b10 : ((st == 2) ? 2'b01 : 2'b00);
        return l;
    endfunction

    // Resets the DUT; returns at the first cycle of phase 0 GREEN.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; ped_req = 1'b0; emerg = 1'b0; emerg_phase = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (lights !== 12'h000 || ps !== 4'd0 || count !== 4'd1 || phase !== 2'd3 || ped_walk !== 1'b0 || ped_wait !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: lights=%h ps=%0d count=%0d phase=%0d walk=%b wait=%b, need 000/0/1/3/0/0",
                     lights, ps, count, phase, ped_walk, ped_wait);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ps !== 4'd0 || count !== 4'd0) begin
            n_err++; $display("FAIL reset_second_allred: ps=%0d count=%0d, need 0/0", ps, count);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ps !== 4'd1 || phase !== 2'd0 || lights !== 12'h202 || count !== 4'(4 - i)) begin
                n_err++;
                $display("FAIL reset_first_green[%0d]: ps=%0d phase=%0d lights=%h count=%0d, need 1/0/202/%0d",
                         i, ps, phase, lights, count, 4 - i);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (ps !== 4'd2 || lights !== 12'h101) begin
            n_err++; $display("FAIL reset_first_yellow: ps=%0d lights=%h, need 2/101", ps, lights);
        end
    endtask

    task automatic test_free_run();
        int t, n;
        logic [3:0] prev;
        int seq [4];
        do_reset();
        t = 0; n = 0; prev = ps;
        while (t < 100 && n < 4) begin
            @(negedge clk);
            t++;
            if (ps == 4'd1 && prev != 4'd1) begin
                seq[n] = int'(phase); n++;
            end
            prev = ps;
        end
        n_cmp++;
        if (n != 4 || t != 30) begin
            n_err++; $display("FAIL free_run_period: %0d cycles, %0d green entries, need 30/4", t, n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (seq[i] != (i + 1) % 4) begin
                n_err++; $display("FAIL free_run_seq[%0d]: phase %0d, need %0d", i, seq[i], (i + 1) % 4);
            end
        end
    endtask

    task automatic test_ped();
        int k, t, w, bad;
        do_reset();
        k = 0;
        while (!(ps == 4'd1 && phase == 2'd1) && k < 50) begin @(negedge clk); k++; end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        n_cmp++;
        if (ped_wait !== 1'b1) begin n_err++; $display("FAIL ped_wait_set: wait=%b, need 1", ped_wait); end
        t = 1;
        while (ps != 4'd3 && t < 30) begin @(negedge clk); t++; end
        n_cmp++;
        if (t != 8) begin n_err++; $display("FAIL ped_walk_latency: %0d cycles, need 8", t); end
        w = 0; bad = 0;
        while (ps == 4'd3 && w < 20) begin
            if (lights !== 12'h000 || ped_walk !== 1'b1 || ped_wait !== 1'b1) bad++;
            @(negedge clk); w++;
        end
        n_cmp++;
        if (w != 5 || bad != 0) begin
            n_err++; $display("FAIL ped_walk_interval: length %0d bad %0d, need 5/0", w, bad);
        end
        n_cmp++;
        if (ps !== 4'd1 || phase !== 2'd2 || ped_wait !== 1'b0 || ped_walk !== 1'b0 || lights !== 12'h022) begin
            n_err++;
            $display("FAIL ped_after_walk: ps=%0d phase=%0d wait=%b walk=%b lights=%h, need 1/2/0/0/022",
                     ps, phase, ped_wait, ped_walk, lights);
        end
    endtask

    task automatic test_emerg();
        logic [3:0] exp_ps [5];
        exp_ps = '{4'd2, 4'd2, 4'd0, 4'd0, 4'd1};
        do_reset();
        @(negedge clk);
        emerg = 1'b1; emerg_phase = 2'd2;
        @(negedge clk);
        n_cmp++;
        if (ps !== 4'd2) begin n_err++; $display("FAIL emerg_to_yellow: ps=%0d, need 2", ps); end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (ps !== 4'd4 || phase !== 2'd2 || lights !== 12'h022 || count !== 4'd0) begin
                n_err++;
                $display("FAIL emerg_preempt[%0d]: ps=%0d phase=%0d lights=%h count=%0d, need 4/2/022/0",
                         i, ps, phase, lights, count);
            end
            @(negedge clk);
        end
        emerg = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ps !== exp_ps[i]) begin
                n_err++; $display("FAIL emerg_release[%0d]: ps=%0d, need %0d", i, ps, exp_ps[i]);
            end
        end
        n_cmp++;
        if (phase !== 2'd3 || lights !== 12'h088) begin
            n_err++; $display("FAIL emerg_resume: phase=%0d lights=%h, need 3/088", phase, lights);
        end
    endtask

    task automatic test_zero_green_and_reset();
        int k;
        green_time = DEF_GREEN;
        green_time[7:4] = 4'd0;
        do_reset();
        k = 0;
        while (!(ps == 4'd1 && phase == 2'd1) && k < 50) begin @(negedge clk); k++; end
        n_cmp++;
        if (count !== 4'd0) begin n_err++; $display("FAIL zero_green_count: count=%0d, need 0", count); end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        n_cmp++;
        if (ps !== 4'd2 || ped_wait !== 1'b1) begin
            n_err++; $display("FAIL zero_green_length: ps=%0d wait=%b, need 2/1", ps, ped_wait);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (lights !== 12'h000 || ps !== 4'd0 || ped_wait !== 1'b0 || count !== 4'd1 || phase !== 2'd3) begin
            n_err++;
            $display("FAIL mid_yellow_reset: lights=%h ps=%0d wait=%b count=%0d phase=%0d, need 000/0/0/1/3",
                     lights, ps, ped_wait, count, phase);
        end
        rst = 1'b1;
        green_time = DEF_GREEN;
    endtask

    task automatic test_ped_and_emerg();
        int k;
        logic [3:0] exp_ps [10];
        exp_ps = '{4'd2, 4'd2, 4'd0, 4'd0, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd1};
        do_reset();
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        k = 0;
        while (ps != 4'd0 && k < 50) begin @(negedge clk); k++; end
        emerg = 1'b1; emerg_phase = 2'd1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ps !== 4'd4 || phase !== 2'd1 || ped_wait !== 1'b1 || lights !== 12'h808) begin
            n_err++;
            $display("FAIL both_preempt_first: ps=%0d phase=%0d wait=%b lights=%h, need 4/1/1/808",
                     ps, phase, ped_wait, lights);
        end
        emerg = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ps !== exp_ps[i]) begin
                n_err++; $display("FAIL both_sequence[%0d]: ps=%0d, need %0d", i, ps, exp_ps[i]);
            end
        end
        n_cmp++;
        if (phase !== 2'd2 || ped_wait !== 1'b0) begin
            n_err++; $display("FAIL both_resume: phase=%0d wait=%b, need 2/0", phase, ped_wait);
        end
    endtask

    task automatic test_random();
        logic [23:0] got, exp;
        int p;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            exp = {4'(m_state), 4'(m_rem - 1), 2'(m_phase), exp_lights(m_state, m_mask),
                   1'(m_state == 3), m_wait};
            got = {ps, count, phase, lights, ped_walk, ped_wait};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                if (n_err < 20) $display("FAIL random[%0d]: dut=%h model=%h", c, got, exp);
            end
            ped_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) emerg = ~emerg;
            if ($urandom_range(0, 19) == 0) emerg_phase = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) begin
                p = $urandom_range(0, NP - 1);
                green_time[p*CW +: CW] = 4'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 49) == 0) yellow_time = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) phase_mask = 24'($urandom);
            rst = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        rst = 1'b1; ped_req = 1'b0; emerg = 1'b0;
        phase_mask = DEF_MASK; green_time = DEF_GREEN; yellow_time = 4'd2;
    endtask

    initial begin
        rst = 1'b0; ped_req = 1'b0; emerg = 1'b0; emerg_phase = '0;
        phase_mask = DEF_MASK; green_time = DEF_GREEN; yellow_time = 4'd2;
        test_reset();
        test_free_run();
        test_ped();
        test_emerg();
        test_zero_green_and_reset();
        test_ped_and_emerg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
